// File: rtl/sram_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter_pkg
// Shared types and constants for the two-requester SRAM arbiter.
//   req_id_t : 1-bit requester identifier
//   REQ0/REQ1: requester identifiers
//   DEF_AW   : default SRAM address width (16 words)
//   DEF_DW   : default SRAM data width
// ---------------------------------------------------------------------------
package sram_rr_arbiter_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Pure combinational grant logic for two requesters: a locked owner keeps
// the grant until its burst is full, otherwise round-robin between two
// valid requesters, otherwise the single valid requester wins.
// Ports:
//   i_valid      [1:0] request present per requester
//   i_lock       [1:0] lock request per requester
//   i_owner_vld        an owner exists (last cycle had a transaction)
//   i_owner            current owner id
//   i_rr_ptr           requester preferred when both are valid
//   i_burst_full       owner has reached its maximum burst length
//   o_grant      [1:0] one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_pick2
  import sram_rr_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic [1:0] i_lock,
  input  logic       i_owner_vld,
  input  req_id_t    i_owner,
  input  req_id_t    i_rr_ptr,
  input  logic       i_burst_full,
  output logic [1:0] o_grant
);

  logic w_owner_valid;
  logic w_owner_lock;

  assign w_owner_valid = (i_owner == REQ1) ? i_valid[1] : i_valid[0];
  assign w_owner_lock  = (i_owner == REQ1) ? i_lock[1]  : i_lock[0];

  always_comb begin
    o_grant = 2'b00;
    if (i_owner_vld && w_owner_valid && w_owner_lock && !i_burst_full) begin
      o_grant = (i_owner == REQ1) ? 2'b10 : 2'b01;
    end else if (i_valid == 2'b11) begin
      o_grant = (i_rr_ptr == REQ1) ? 2'b10 : 2'b01;
    end else if (i_valid[0]) begin
      o_grant = 2'b01;
    end else if (i_valid[1]) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter
// Shares one single-port SRAM (registered read data) between two requesters
// with valid/ready handshakes, round-robin fairness, bounded burst lock and
// one-cycle read responses routed back to the issuing requester.
// Optional build macro: SRAM_RR_ARBITER_STATS_EN adds per-requester
// saturating grant counters (o_gnt0_cnt / o_gnt1_cnt).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_reqN_valid/we/lock/addr/wdata  request from requester N
//   o_reqN_ready                     request accepted this cycle
//   o_rspN_valid/rdata               read response to requester N
//   o_mem_we/addr/wdata, i_mem_rdata SRAM port
//   o_gnt0_cnt/o_gnt1_cnt            accepted transaction counts (stats build)
// ---------------------------------------------------------------------------
module sram_rr_arbiter
  import sram_rr_arbiter_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0_valid,
  output logic          o_req0_ready,
  input  logic          i_req0_we,
  input  logic          i_req0_lock,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_wdata,
  input  logic          i_req1_valid,
  output logic          o_req1_ready,
  input  logic          i_req1_we,
  input  logic          i_req1_lock,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_wdata,
  output logic          o_rsp0_valid,
  output logic [DW-1:0] o_rsp0_rdata,
  output logic          o_rsp1_valid,
  output logic [DW-1:0] o_rsp1_rdata,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
`ifdef SRAM_RR_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] o_gnt0_cnt,
  output logic [CNT_W-1:0] o_gnt1_cnt
`endif
);

  // Wide enough to hold MAX_BURST itself, where the count saturates.
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

  // Reject configurations that cannot work at elaboration.
  if (MAX_BURST < 1 || CNT_W < 1) begin : g_param_check
    $error("sram_rr_arbiter: MAX_BURST and CNT_W must be >= 1");
  end

  req_id_t       r_rr_ptr;
  req_id_t       r_owner;
  logic          r_owner_vld;
  logic [BW-1:0] r_burst_cnt;
  logic          r_rd_pending;
  req_id_t       r_rd_tag;

  logic [1:0]    w_grant;
  logic          w_hs;
  req_id_t       w_gnt_id;
  logic          w_burst_full;

  assign w_burst_full = (r_burst_cnt >= MAX_CNT);

  rr_pick2 u_pick (
    .i_valid      ({i_req1_valid, i_req0_valid}),
    .i_lock       ({i_req1_lock, i_req0_lock}),
    .i_owner_vld  (r_owner_vld),
    .i_owner      (r_owner),
    .i_rr_ptr     (r_rr_ptr),
    .i_burst_full (w_burst_full),
    .o_grant      (w_grant)
  );

  // A grant is only ever given to a valid requester, so grant == handshake.
  assign o_req0_ready = w_grant[0];
  assign o_req1_ready = w_grant[1];
  assign w_hs         = |w_grant;
  assign w_gnt_id     = w_grant[1] ? REQ1 : REQ0;

  // SRAM port is driven from the granted requester; all-zero when idle so
  // the SRAM does a harmless read of address 0.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_grant[0]) begin
      o_mem_we    = i_req0_we;
      o_mem_addr  = i_req0_addr;
      o_mem_wdata = i_req0_wdata;
    end else if (w_grant[1]) begin
      o_mem_we    = i_req1_we;
      o_mem_addr  = i_req1_addr;
      o_mem_wdata = i_req1_wdata;
    end
  end

  // Arbitration history and read tracking. An idle cycle drops ownership
  // so a later lock must first win arbitration again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= REQ0;
      r_owner      <= REQ0;
      r_owner_vld  <= 1'b0;
      r_burst_cnt  <= '0;
      r_rd_pending <= 1'b0;
      r_rd_tag     <= REQ0;
    end else begin
      r_rd_pending <= w_hs && !o_mem_we;
      if (w_hs) begin
        r_rd_tag    <= w_gnt_id;
        r_rr_ptr    <= ~w_gnt_id;
        r_owner     <= w_gnt_id;
        r_owner_vld <= 1'b1;
        if (r_owner_vld && (r_owner == w_gnt_id)) begin
          if (!w_burst_full) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end else begin
          r_burst_cnt <= BW'(1);
        end
      end else begin
        r_owner_vld <= 1'b0;
        r_burst_cnt <= '0;
      end
    end
  end

  // Read data arrives from the SRAM one cycle after the accepted read.
  assign o_rsp0_valid = r_rd_pending && (r_rd_tag == REQ0);
  assign o_rsp1_valid = r_rd_pending && (r_rd_tag == REQ1);
  assign o_rsp0_rdata = o_rsp0_valid ? i_mem_rdata : '0;
  assign o_rsp1_rdata = o_rsp1_valid ? i_mem_rdata : '0;

`ifdef SRAM_RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_gnt0_cnt;
  logic [CNT_W-1:0] r_gnt1_cnt;

  // Saturating per-requester accepted-transaction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else begin
      if (w_grant[0] && (r_gnt0_cnt != '1)) begin
        r_gnt0_cnt <= r_gnt0_cnt + 1'b1;
      end
      if (w_grant[1] && (r_gnt1_cnt != '1)) begin
        r_gnt1_cnt <= r_gnt1_cnt + 1'b1;
      end
    end
  end

  assign o_gnt0_cnt = r_gnt0_cnt;
  assign o_gnt1_cnt = r_gnt1_cnt;
`endif

endmodule
